// File: rtl/cortex_m0_sysexc_ctrl.sv
// System-exception pend/arbitration stage for NMI, PendSV and SysTick.
// Latches pend causes, ranks eligible exceptions and hands one winner to the core.
module cortex_m0_sysexc_ctrl #(
  parameter int PRI_BITS = 2,
  parameter int RANK_W   = PRI_BITS + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              systick_evt,
  input  logic              nmi_in,
  input  logic              icsr_wr,
  input  logic [31:0]       icsr_wdata,
  input  logic              shpr3_wr,
  input  logic [31:0]       shpr3_wdata,
  input  logic              primask,
  input  logic [RANK_W-1:0] cur_rank,
  input  logic              exc_ack,
  input  logic              exc_ret,
  input  logic [5:0]        exc_ret_num,
  output logic              exc_req,
  output logic [5:0]        exc_num,
  output logic [2:0]        pend_bits,
  output logic [2:0]        active_bits,
  output logic [31:0]       shpr3_rdata
);

  localparam logic [5:0]        NUM_NMI   = 6'd2;
  localparam logic [5:0]        NUM_SV    = 6'd14;
  localparam logic [5:0]        NUM_ST    = 6'd15;
  localparam logic [RANK_W-1:0] RANK_NMI  = '0;
  localparam logic [RANK_W-1:0] RANK_BASE = RANK_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2
  } state_t;

  state_t state, state_next;

  logic                pend_nmi, pend_sv, pend_st;
  logic                act_nmi, act_sv, act_st;
  logic [PRI_BITS-1:0] pri_sv, pri_st;
  logic                nmi_q, nmi_armed;
  logic                req_next;
  logic [5:0]          num_next;

  // ICSR field decode
  logic nmi_set_w, sv_set_w, sv_clr_w, st_set_w, st_clr_w;
  assign nmi_set_w = icsr_wr & icsr_wdata[31];
  assign sv_set_w  = icsr_wr & icsr_wdata[28];
  assign sv_clr_w  = icsr_wr & icsr_wdata[27];
  assign st_set_w  = icsr_wr & icsr_wdata[26];
  assign st_clr_w  = icsr_wr & icsr_wdata[25];

  logic unused_wdata;
  assign unused_wdata = &{1'b0, icsr_wdata[30:29], icsr_wdata[24:0],
                          shpr3_wdata[31-PRI_BITS:24], shpr3_wdata[23-PRI_BITS:0]};

  // nmi_armed suppresses a false edge when nmi_in is already high as reset releases.
  logic nmi_edge;
  assign nmi_edge = nmi_in & ~nmi_q & nmi_armed;

  // Handshake: exc_req/exc_num are valid from REQ entry and stay frozen until the
  // cycle exc_ack=1 (ready) is seen in REQ; that cycle completes the transfer.
  logic ack_fire, ack_nmi, ack_sv, ack_st;
  assign ack_fire = (state == REQ) & exc_ack;
  assign ack_nmi  = ack_fire & (exc_num == NUM_NMI);
  assign ack_sv   = ack_fire & (exc_num == NUM_SV);
  assign ack_st   = ack_fire & (exc_num == NUM_ST);

  logic inflight_sv, inflight_st;
  assign inflight_sv = (state == REQ) & (exc_num == NUM_SV);
  assign inflight_st = (state == REQ) & (exc_num == NUM_ST);

  logic set_nmi, set_sv, set_st, clr_sv, clr_st;
  assign set_nmi = nmi_edge | nmi_set_w;
  assign set_sv  = sv_set_w & ~sv_clr_w;
  assign set_st  = systick_evt | (st_set_w & ~st_clr_w);
  assign clr_sv  = ack_sv | (sv_clr_w & ~sv_set_w & ~inflight_sv);
  assign clr_st  = ack_st | (st_clr_w & ~st_set_w & ~inflight_st);

  logic ret_nmi, ret_sv, ret_st;
  assign ret_nmi = exc_ret & (exc_ret_num == NUM_NMI);
  assign ret_sv  = exc_ret & (exc_ret_num == NUM_SV);
  assign ret_st  = exc_ret & (exc_ret_num == NUM_ST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_q     <= 1'b0;
      nmi_armed <= 1'b0;
      pend_nmi  <= 1'b0;
      pend_sv   <= 1'b0;
      pend_st   <= 1'b0;
      act_nmi   <= 1'b0;
      act_sv    <= 1'b0;
      act_st    <= 1'b0;
      pri_sv    <= '0;
      pri_st    <= '0;
    end else begin
      nmi_q     <= nmi_in;
      nmi_armed <= 1'b1;

      if (set_nmi)      pend_nmi <= 1'b1;
      else if (ack_nmi) pend_nmi <= 1'b0;
      if (set_sv)       pend_sv  <= 1'b1;
      else if (clr_sv)  pend_sv  <= 1'b0;
      if (set_st)       pend_st  <= 1'b1;
      else if (clr_st)  pend_st  <= 1'b0;

      // Acceptance outranks a coincident return for the same exception.
      if (ack_nmi)      act_nmi <= 1'b1;
      else if (ret_nmi) act_nmi <= 1'b0;
      if (ack_sv)       act_sv  <= 1'b1;
      else if (ret_sv)  act_sv  <= 1'b0;
      if (ack_st)       act_st  <= 1'b1;
      else if (ret_st)  act_st  <= 1'b0;

      if (shpr3_wr) begin
        pri_st <= shpr3_wdata[31 -: PRI_BITS];
        pri_sv <= shpr3_wdata[23 -: PRI_BITS];
      end
    end
  end

  logic [RANK_W-1:0] rank_sv, rank_st;
  assign rank_sv = RANK_BASE + RANK_W'(pri_sv);
  assign rank_st = RANK_BASE + RANK_W'(pri_st);

  logic elig_nmi, elig_sv, elig_st;
  assign elig_nmi = pend_nmi & ~act_nmi & (RANK_NMI < cur_rank);
  assign elig_sv  = pend_sv & ~act_sv & ~primask & (rank_sv < cur_rank);
  assign elig_st  = pend_st & ~act_st & ~primask & (rank_st < cur_rank);

  // NMI always holds rank 0; between the configurable ones a tie favours PendSV.
  logic       any_elig;
  logic [5:0] winner;
  always_comb begin
    any_elig = elig_nmi | elig_sv | elig_st;
    winner   = NUM_ST;
    if (elig_nmi)                                  winner = NUM_NMI;
    else if (elig_sv && (!elig_st || rank_sv <= rank_st)) winner = NUM_SV;
  end

  always_comb begin
    state_next = state;
    req_next   = exc_req;
    num_next   = exc_num;
    case (state)
      IDLE: begin
        if (any_elig) begin
          req_next   = 1'b1;
          num_next   = winner;
          state_next = REQ;
        end
      end
      REQ: begin
        if (exc_ack) begin
          req_next   = 1'b0;
          state_next = ACKED;
        end
      end
      ACKED: state_next = IDLE;
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      exc_req <= 1'b0;
      exc_num <= 6'd0;
    end else begin
      state   <= state_next;
      exc_req <= req_next;
      exc_num <= num_next;
    end
  end

  assign pend_bits   = {pend_nmi, pend_sv, pend_st};
  assign active_bits = {act_nmi, act_sv, act_st};

  always_comb begin
    shpr3_rdata = 32'd0;
    shpr3_rdata[31 -: PRI_BITS] = pri_st;
    shpr3_rdata[23 -: PRI_BITS] = pri_sv;
  end

endmodule

// File: tb/tb_cortex_m0_sysexc_ctrl.sv
// Directed bench for cortex_m0_sysexc_ctrl: pend latching, arbitration, handshake and reset.
module tb_cortex_m0_sysexc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        systick_evt;
  logic        nmi_in;
  logic        icsr_wr;
  logic [31:0] icsr_wdata;
  logic        shpr3_wr;
  logic [31:0] shpr3_wdata;
  logic        primask;
  logic [2:0]  cur_rank;
  logic        exc_ack;
  logic        exc_ret;
  logic [5:0]  exc_ret_num;
  logic        exc_req;
  logic [5:0]  exc_num;
  logic [2:0]  pend_bits;
  logic [2:0]  active_bits;
  logic [31:0] shpr3_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  cortex_m0_sysexc_ctrl dut (
    .clk(clk), .reset(reset), .systick_evt(systick_evt), .nmi_in(nmi_in),
    .icsr_wr(icsr_wr), .icsr_wdata(icsr_wdata), .shpr3_wr(shpr3_wr),
    .shpr3_wdata(shpr3_wdata), .primask(primask), .cur_rank(cur_rank),
    .exc_ack(exc_ack), .exc_ret(exc_ret), .exc_ret_num(exc_ret_num),
    .exc_req(exc_req), .exc_num(exc_num), .pend_bits(pend_bits),
    .active_bits(active_bits), .shpr3_rdata(shpr3_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic icsr_write(input logic [31:0] d);
    icsr_wr = 1'b1; icsr_wdata = d;
    tick();
    icsr_wr = 1'b0; icsr_wdata = 32'd0;
  endtask

  task automatic shpr3_write(input logic [31:0] d);
    shpr3_wr = 1'b1; shpr3_wdata = d;
    tick();
    shpr3_wr = 1'b0; shpr3_wdata = 32'd0;
  endtask

  task automatic ack();
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
  endtask

  task automatic ret(input logic [5:0] n);
    exc_ret = 1'b1; exc_ret_num = n;
    tick();
    exc_ret = 1'b0; exc_ret_num = 6'd0;
  endtask

  task automatic test_reset();
    systick_evt = 0; icsr_wr = 0; icsr_wdata = 0; shpr3_wr = 0; shpr3_wdata = 0;
    primask = 0; cur_rank = 3'd7; exc_ack = 0; exc_ret = 0; exc_ret_num = 0;
    nmi_in = 1'b1; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    vec_cnt++; if (pend_bits !== 3'b000) begin err_cnt++; $display("FAIL rst_pend: got %b want 000", pend_bits); end
    vec_cnt++; if (exc_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req: got %b want 0", exc_req); end
    vec_cnt++; if (exc_num !== 6'd0) begin err_cnt++; $display("FAIL rst_num: got %0d want 0", exc_num); end
    vec_cnt++; if (active_bits !== 3'b000) begin err_cnt++; $display("FAIL rst_act: got %b want 000", active_bits); end
    vec_cnt++; if (shpr3_rdata !== 32'd0) begin err_cnt++; $display("FAIL rst_shpr3: got %h want 0", shpr3_rdata); end
    nmi_in = 1'b0;
    tick();
  endtask

  task automatic test_systick();
    systick_evt = 1'b1;
    tick();
    systick_evt = 1'b0;
    vec_cnt++; if (pend_bits !== 3'b001) begin err_cnt++; $display("FAIL st_pend: got %b want 001", pend_bits); end
    vec_cnt++; if (exc_req !== 1'b0) begin err_cnt++; $display("FAIL st_req_early: got %b want 0", exc_req); end
    tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd15) begin err_cnt++; $display("FAIL st_req: got %b/%0d want 1/15", exc_req, exc_num); end
    ack();
    vec_cnt++; if (pend_bits !== 3'b000 || active_bits !== 3'b001 || exc_req !== 1'b0) begin err_cnt++; $display("FAIL st_ack: got p=%b a=%b r=%b want 000/001/0", pend_bits, active_bits, exc_req); end
    tick();
    ret(6'd15);
    vec_cnt++; if (active_bits !== 3'b000) begin err_cnt++; $display("FAIL st_ret: got %b want 000", active_bits); end
  endtask

  task automatic test_priority();
    shpr3_write(32'hC040_0000);
    vec_cnt++; if (shpr3_rdata !== 32'hC040_0000) begin err_cnt++; $display("FAIL pri_rdata: got %h want c0400000", shpr3_rdata); end
    icsr_write(32'h1400_0000);
    vec_cnt++; if (pend_bits !== 3'b011) begin err_cnt++; $display("FAIL pri_pend: got %b want 011", pend_bits); end
    tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd14) begin err_cnt++; $display("FAIL pri_first: got %b/%0d want 1/14", exc_req, exc_num); end
    cur_rank = 3'd3;
    ack();
    vec_cnt++; if (pend_bits !== 3'b001 || active_bits !== 3'b010) begin err_cnt++; $display("FAIL pri_ack: got p=%b a=%b want 001/010", pend_bits, active_bits); end
    tick(); tick(); tick();
    vec_cnt++; if (exc_req !== 1'b0) begin err_cnt++; $display("FAIL pri_rank3: got %b want 0", exc_req); end
    cur_rank = 3'd5;
    tick(); tick();
    vec_cnt++; if (exc_req !== 1'b0) begin err_cnt++; $display("FAIL pri_rank5: got %b want 0", exc_req); end
    cur_rank = 3'd6;
    tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd15) begin err_cnt++; $display("FAIL pri_rank6: got %b/%0d want 1/15", exc_req, exc_num); end
    ack();
    cur_rank = 3'd7;
    ret(6'd14);
    ret(6'd15);
    vec_cnt++; if (active_bits !== 3'b000 || pend_bits !== 3'b000) begin err_cnt++; $display("FAIL pri_clean: got a=%b p=%b want 000/000", active_bits, pend_bits); end
  endtask

  task automatic test_tie();
    shpr3_write(32'h8080_0000);
    icsr_write(32'h1400_0000);
    tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd14) begin err_cnt++; $display("FAIL tie_win: got %b/%0d want 1/14", exc_req, exc_num); end
    nmi_in = 1'b1;
    tick();
    vec_cnt++; if (pend_bits !== 3'b111) begin err_cnt++; $display("FAIL tie_nmi_pend: got %b want 111", pend_bits); end
    tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd14) begin err_cnt++; $display("FAIL tie_hold: got %b/%0d want 1/14", exc_req, exc_num); end
    ack();
    vec_cnt++; if (pend_bits !== 3'b101 || active_bits !== 3'b010 || exc_req !== 1'b0) begin err_cnt++; $display("FAIL tie_ack: got p=%b a=%b r=%b want 101/010/0", pend_bits, active_bits, exc_req); end
    tick(); tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd2) begin err_cnt++; $display("FAIL tie_nmi_req: got %b/%0d want 1/2", exc_req, exc_num); end
    ack();
    tick(); tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd15) begin err_cnt++; $display("FAIL tie_st_req: got %b/%0d want 1/15", exc_req, exc_num); end
    ack();
    vec_cnt++; if (active_bits !== 3'b111 || pend_bits !== 3'b000) begin err_cnt++; $display("FAIL tie_all_act: got a=%b p=%b want 111/000", active_bits, pend_bits); end
    nmi_in = 1'b0;
    ret(6'd2); ret(6'd14); ret(6'd15);
    vec_cnt++; if (active_bits !== 3'b000) begin err_cnt++; $display("FAIL tie_ret: got %b want 000", active_bits); end
  endtask

  task automatic test_primask();
    primask = 1'b1;
    icsr_write(32'h9000_0000);
    vec_cnt++; if (pend_bits !== 3'b110) begin err_cnt++; $display("FAIL pm_pend: got %b want 110", pend_bits); end
    tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd2) begin err_cnt++; $display("FAIL pm_nmi: got %b/%0d want 1/2", exc_req, exc_num); end
    ack();
    tick(); tick(); tick();
    vec_cnt++; if (exc_req !== 1'b0 || pend_bits !== 3'b010) begin err_cnt++; $display("FAIL pm_masked: got r=%b p=%b want 0/010", exc_req, pend_bits); end
    icsr_write(32'h1800_0000);
    vec_cnt++; if (pend_bits !== 3'b010) begin err_cnt++; $display("FAIL pm_setclr: got %b want 010", pend_bits); end
    systick_evt = 1'b1;
    icsr_write(32'h0200_0000);
    systick_evt = 1'b0;
    vec_cnt++; if (pend_bits !== 3'b011) begin err_cnt++; $display("FAIL pm_evt_wins: got %b want 011", pend_bits); end
    icsr_write(32'h0800_0000);
    vec_cnt++; if (pend_bits !== 3'b001) begin err_cnt++; $display("FAIL pm_svclr: got %b want 001", pend_bits); end
    icsr_write(32'h0200_0000);
    vec_cnt++; if (pend_bits !== 3'b000) begin err_cnt++; $display("FAIL pm_stclr: got %b want 000", pend_bits); end
    ret(6'd2);
    vec_cnt++; if (active_bits !== 3'b000) begin err_cnt++; $display("FAIL pm_ret: got %b want 000", active_bits); end
    primask = 1'b0;
  endtask

  task automatic test_back_to_back();
    icsr_write(32'h1000_0000);
    tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd14) begin err_cnt++; $display("FAIL b2b_req: got %b/%0d want 1/14", exc_req, exc_num); end
    icsr_write(32'h0800_0000);
    vec_cnt++; if (pend_bits !== 3'b010 || exc_req !== 1'b1) begin err_cnt++; $display("FAIL b2b_clr_ignored: got p=%b r=%b want 010/1", pend_bits, exc_req); end
    exc_ack = 1'b1;
    icsr_write(32'h1000_0000);
    exc_ack = 1'b0;
    vec_cnt++; if (pend_bits !== 3'b010 || active_bits !== 3'b010) begin err_cnt++; $display("FAIL b2b_repend: got p=%b a=%b want 010/010", pend_bits, active_bits); end
    ret(6'd14);
    tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd14) begin err_cnt++; $display("FAIL b2b_rereq: got %b/%0d want 1/14", exc_req, exc_num); end
    exc_ack = 1'b1; exc_ret = 1'b1; exc_ret_num = 6'd14;
    tick();
    exc_ack = 1'b0; exc_ret = 1'b0; exc_ret_num = 6'd0;
    vec_cnt++; if (active_bits !== 3'b010 || pend_bits !== 3'b000) begin err_cnt++; $display("FAIL b2b_ack_ret: got a=%b p=%b want 010/000", active_bits, pend_bits); end
    ret(6'd3);
    vec_cnt++; if (active_bits !== 3'b010) begin err_cnt++; $display("FAIL b2b_bad_ret: got %b want 010", active_bits); end
    ret(6'd14);
    vec_cnt++; if (active_bits !== 3'b000) begin err_cnt++; $display("FAIL b2b_ret: got %b want 000", active_bits); end
  endtask

  task automatic test_async_reset();
    icsr_write(32'h1400_0000);
    tick();
    ack();
    tick(); tick();
    vec_cnt++; if (exc_req !== 1'b1 || exc_num !== 6'd15 || active_bits !== 3'b010) begin err_cnt++; $display("FAIL ar_setup: got r=%b n=%0d a=%b want 1/15/010", exc_req, exc_num, active_bits); end
    #2;
    reset = 1'b1;
    #1;
    vec_cnt++; if (exc_req !== 1'b0 || exc_num !== 6'd0) begin err_cnt++; $display("FAIL ar_req: got %b/%0d want 0/0", exc_req, exc_num); end
    vec_cnt++; if (pend_bits !== 3'b000 || active_bits !== 3'b000) begin err_cnt++; $display("FAIL ar_bits: got p=%b a=%b want 000/000", pend_bits, active_bits); end
    vec_cnt++; if (shpr3_rdata !== 32'd0) begin err_cnt++; $display("FAIL ar_shpr3: got %h want 0", shpr3_rdata); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_systick();
    test_priority();
    test_tie();
    test_primask();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cortex_m0_sysexc_ctrl.md
Name: cortex_m0_sysexc_ctrl

Overview:
- System-exception pend/arbitration stage that sits directly downstream of the SysTick timer.
- Latches SysTick wrap events, PendSV set/clear and NMI edges into pending bits.
- Applies the SHPR3 priorities and PRIMASK, then presents the single winning exception to the core's exception-entry logic over a req/ack handshake.
- Tracks the active state of each exception until the core signals exception return.

Parameters:
- PRI_BITS, 2, implemented priority bits per configurable exception (Cortex-M0: 2).
- RANK_W, PRI_BITS+1, width of the execution-rank encoding.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- systick_evt  in  1  one-cycle pulse from SysTick: counter reached 0 with TICKINT=1
- nmi_in  in  1  NMI level; a rising edge pends NMI
- icsr_wr  in  1  ICSR write strobe
- icsr_wdata  in  32  ICSR write data: [31] NMIPENDSET, [28] PENDSVSET, [27] PENDSVCLR, [26] PENDSTSET, [25] PENDSTCLR
- shpr3_wr  in  1  SHPR3 write strobe
- shpr3_wdata  in  32  [31:32-PRI_BITS] SysTick priority, [23:24-PRI_BITS] PendSV priority
- primask  in  1  1 = mask all configurable-priority exceptions
- cur_rank  in  RANK_W  current execution rank: 0 = NMI, 1 = HardFault, 2+p = configurable priority p, all-ones = thread
- exc_ack  in  1  core accepts the presented exception
- exc_ret  in  1  one-cycle exception-return pulse
- exc_ret_num  in  6  exception number being returned from
- exc_req  out  1  exception request to core
- exc_num  out  6  requested exception: 2 = NMI, 14 = PendSV, 15 = SysTick
- pend_bits  out  3  {NMI, PendSV, SysTick} pending, for ICSR readback
- active_bits  out  3  {NMI, PendSV, SysTick} active
- shpr3_rdata  out  32  stored priorities in their field positions, all other bits 0

Behaviour:
- Reset (asynchronous) values:
  - all pending, active and priority registers = 0
  - nmi edge register = 0
  - exc_req = 0, exc_num = 0
  - FSM = IDLE
- Pending-bit updates, all registered and visible one cycle after the cause:
  - systick_evt sets pend_st.
  - PENDSTSET sets pend_st. PENDSTCLR clears it.
  - PENDSVSET sets pend_sv. PENDSVCLR clears it.
  - A SET and CLR for the same exception in one write leaves that bit unchanged.
  - systick_evt in the same cycle as PENDSTCLR leaves pend_st = 1 (event wins).
  - An NMI rising edge (nmi_in=1, previous sample 0) or NMIPENDSET sets pend_nmi. There is no NMI clear.
- Rank computation:
  - NMI rank = 0.
  - SysTick/PendSV rank = 2 + stored priority.
- Eligibility: an exception is eligible when all of the following hold:
  - it is pending;
  - it is not already active;
  - its rank < cur_rank (strict);
  - it is not masked: primask=1 masks SysTick and PendSV, never NMI.
- Winner: the lowest rank among eligible exceptions. Ties go to the lower exception number (PendSV beats SysTick).
- FSM:
  - IDLE: if any exception is eligible, register the winner into exc_num, set exc_req=1, go to REQ. Request latency from a pending bit becoming visible is 1 cycle, so 2 cycles from systick_evt.
  - REQ:
    - exc_req and exc_num are held stable, with no retraction and no re-arbitration, even if a higher-priority exception pends or cur_rank/primask change.
    - A CLR write targeting the in-flight exception is ignored.
    - On exc_ack=1: clear the pend bit, set the active bit, drop exc_req, go to ACKED.
    - A new event for the same exception in the ack cycle re-pends it (pend=1 after the ack).
  - ACKED: one-cycle bubble so cur_rank can update; always go to IDLE.
- exc_ret=1 clears the active bit matching exc_ret_num (2/14/15); other numbers are ignored.
  - exc_ret and exc_ack may coincide and act independently.
  - If exc_ret and exc_ack coincide on the same number, the bit ends active (ack wins).
- SHPR3 writes take effect next cycle. An arbitration already latched in REQ is unaffected.
- exc_ack in IDLE or ACKED is ignored.

Test Plan:
- Reset with nmi_in=1, release, hold nmi_in=1 -> no NMI pended (no edge); pend_bits=000, exc_req=0.
- cur_rank=7, primask=0, systick_evt at edge k -> pend_bits=001 after k, exc_req=1 with exc_num=15 after k+1. exc_ack -> pend_bits=000, active_bits=001. exc_ret with num 15 -> active_bits=000.
- SHPR3 SysTick=3, PendSV=1; pend both in the same cycle with cur_rank=7 -> exc_num=14 first. Set cur_rank=3, ack -> SysTick (rank 5) not requested until cur_rank>5.
- Tie: both priorities 2, both pending -> exc_num=14. In REQ, pulse nmi_in 0→1 -> exc_num stays 14 until ack, then the next request is exc_num=2.
- primask=1 with PendSV and NMI pending -> exc_num=2 only. ICSR write with both PENDSVSET and PENDSVCLR -> pend_sv unchanged. PENDSTCLR with simultaneous systick_evt -> pend_st=1.
- Assert reset asynchronously mid-REQ (between clock edges) -> exc_req=0, pend_bits=000, active_bits=000 immediately, without waiting for a clock edge.
